// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// shadow-slot layouts, their bubble values and the forward-mux encodings.
package hazard_ctrl_pkg;

    localparam logic [1:0] NOforward  = 2'b00;
    localparam logic [1:0] forwardMEM = 2'b01;
    localparam logic [1:0] forwardWB  = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
        logic [4:0] rd;
        logic       wren;
        logic       load;
    } ex_slot_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wren;
        logic       load;
    } mem_slot_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wren;
    } wb_slot_t;

    localparam ex_slot_t  EX_BUBBLE  = '0;
    localparam mem_slot_t MEM_BUBBLE = '0;
    localparam wb_slot_t  WB_BUBBLE  = '0;

    // x0 is hardwired, so a write to it never produces a value to forward
    function automatic logic slot_writes(
        input logic       valid,
        input logic       wren,
        input logic [4:0] rd,
        input logic [4:0] r
    );
        return valid && wren && (rd == r) && (r != 5'd0);
    endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Forward-mux select for one EX source operand, from the MEM and WB slots.
// The younger MEM result wins; loads in MEM have no data yet.
module fwd_sel_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_addr_i,
    input  logic       rs_used_i,
    input  mem_slot_t  mem_i,
    input  wb_slot_t   wb_i,
    output logic [1:0] sel_o
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = rs_used_i && !mem_i.load
                  && slot_writes(mem_i.valid, mem_i.wren, mem_i.rd, rs_addr_i);
        wb_hit  = rs_used_i
                  && slot_writes(wb_i.valid, wb_i.wren, wb_i.rd, rs_addr_i);
        sel_o   = NOforward;
        if (mem_hit) begin
            sel_o = forwardMEM;
        end else if (wb_hit) begin
            sel_o = forwardWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: shadows EX/MEM/WB register usage and drives forwarding,
// pipeline enables/flushes, load-use bubbles, branch squash and memory freeze.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_rs1_addr_i,
    input  logic [4:0]       ID_rs2_addr_i,
    input  logic             ID_rs1_used_i,
    input  logic             ID_rs2_used_i,
    input  logic [4:0]       ID_rd_addr_i,
    input  logic             ID_rd_wren_i,
    input  logic             ID_mem_rden_i,
    input  logic             EX_br_taken_i,
    input  logic             MEM_dmem_ready_i,
    output logic [1:0]       forward_rs1_sel_o,
    output logic [1:0]       forward_rs2_sel_o,
    output logic             pc_en_o,
    output logic             IF_ID_en_o,
    output logic             ID_EX_en_o,
    output logic             EX_MEM_en_o,
    output logic             MEM_WB_en_o,
    output logic             IF_ID_flush_o,
    output logic             ID_EX_flush_o,
    output logic [CNT_W-1:0] loaduse_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    ex_slot_t         ex_q, ex_d;
    mem_slot_t        mem_q, mem_d;
    wb_slot_t         wb_q, wb_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

    logic mem_stall;
    logic load_use;

    always_comb begin
        mem_stall = !MEM_dmem_ready_i;
        load_use  = ex_q.valid && ex_q.load && ex_q.wren
                    && (ex_q.rd != 5'd0)
                    && (((ex_q.rd == ID_rs1_addr_i) && ID_rs1_used_i)
                     || ((ex_q.rd == ID_rs2_addr_i) && ID_rs2_used_i));
    end

    always_comb begin
        pc_en_o       = 1'b1;
        IF_ID_en_o    = 1'b1;
        ID_EX_en_o    = 1'b1;
        EX_MEM_en_o   = 1'b1;
        MEM_WB_en_o   = 1'b1;
        IF_ID_flush_o = 1'b0;
        ID_EX_flush_o = 1'b0;
        lu_cnt_d      = lu_cnt_q;
        fl_cnt_d      = fl_cnt_q;

        ex_d.valid    = 1'b1;
        ex_d.rs1      = ID_rs1_addr_i;
        ex_d.rs2      = ID_rs2_addr_i;
        ex_d.rs1_used = ID_rs1_used_i;
        ex_d.rs2_used = ID_rs2_used_i;
        ex_d.rd       = ID_rd_addr_i;
        ex_d.wren     = ID_rd_wren_i;
        ex_d.load     = ID_mem_rden_i;
        mem_d         = '{valid: ex_q.valid, rd: ex_q.rd,
                          wren: ex_q.wren, load: ex_q.load};
        wb_d          = '{valid: mem_q.valid, rd: mem_q.rd,
                          wren: mem_q.wren};

        // reset wins over a pending stall so the pipe restarts cleanly
        if (rst_i) begin
            ex_d  = EX_BUBBLE;
            mem_d = MEM_BUBBLE;
            wb_d  = WB_BUBBLE;
        end else if (mem_stall) begin
            pc_en_o     = 1'b0;
            IF_ID_en_o  = 1'b0;
            ID_EX_en_o  = 1'b0;
            EX_MEM_en_o = 1'b0;
            MEM_WB_en_o = 1'b0;
            ex_d        = ex_q;
            mem_d       = mem_q;
            wb_d        = wb_q;
        end else if (EX_br_taken_i) begin
            IF_ID_flush_o = 1'b1;
            ID_EX_flush_o = 1'b1;
            ex_d          = EX_BUBBLE;
            if (fl_cnt_q != '1) begin
                fl_cnt_d = fl_cnt_q + CNT_W'(1);
            end
        end else if (load_use) begin
            pc_en_o       = 1'b0;
            IF_ID_en_o    = 1'b0;
            ID_EX_flush_o = 1'b1;
            ex_d          = EX_BUBBLE;
            if (lu_cnt_q != '1) begin
                lu_cnt_d = lu_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q     <= EX_BUBBLE;
            mem_q    <= MEM_BUBBLE;
            wb_q     <= WB_BUBBLE;
            lu_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            lu_cnt_q <= lu_cnt_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    fwd_sel_unit u_fwd_rs1 (
        .rs_addr_i (ex_q.rs1),
        .rs_used_i (ex_q.rs1_used),
        .mem_i     (mem_q),
        .wb_i      (wb_q),
        .sel_o     (forward_rs1_sel_o)
    );

    fwd_sel_unit u_fwd_rs2 (
        .rs_addr_i (ex_q.rs2),
        .rs_used_i (ex_q.rs2_used),
        .mem_i     (mem_q),
        .wb_i      (wb_q),
        .sel_o     (forward_rs2_sel_o)
    );

    assign loaduse_cnt_o = lu_cnt_q;
    assign flush_cnt_o   = fl_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expectations are queued per step and
// compared against the DUT outputs mid-cycle.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    localparam int S_F1 = 0;
    localparam int S_F2 = 1;
    localparam int S_EN = 2;
    localparam int S_FL = 3;
    localparam int S_LU = 4;
    localparam int S_FC = 5;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       ID_rs1_addr_i, ID_rs2_addr_i, ID_rd_addr_i;
    logic             ID_rs1_used_i, ID_rs2_used_i;
    logic             ID_rd_wren_i, ID_mem_rden_i;
    logic             EX_br_taken_i, MEM_dmem_ready_i;
    logic [1:0]       forward_rs1_sel_o, forward_rs2_sel_o;
    logic             pc_en_o, IF_ID_en_o, ID_EX_en_o;
    logic             EX_MEM_en_o, MEM_WB_en_o;
    logic             IF_ID_flush_o, ID_EX_flush_o;
    logic [CNT_W-1:0] loaduse_cnt_o, flush_cnt_o;

    typedef struct {
        int          sig;
        logic [15:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .ID_rs1_addr_i     (ID_rs1_addr_i),
        .ID_rs2_addr_i     (ID_rs2_addr_i),
        .ID_rs1_used_i     (ID_rs1_used_i),
        .ID_rs2_used_i     (ID_rs2_used_i),
        .ID_rd_addr_i      (ID_rd_addr_i),
        .ID_rd_wren_i      (ID_rd_wren_i),
        .ID_mem_rden_i     (ID_mem_rden_i),
        .EX_br_taken_i     (EX_br_taken_i),
        .MEM_dmem_ready_i  (MEM_dmem_ready_i),
        .forward_rs1_sel_o (forward_rs1_sel_o),
        .forward_rs2_sel_o (forward_rs2_sel_o),
        .pc_en_o           (pc_en_o),
        .IF_ID_en_o        (IF_ID_en_o),
        .ID_EX_en_o        (ID_EX_en_o),
        .EX_MEM_en_o       (EX_MEM_en_o),
        .MEM_WB_en_o       (MEM_WB_en_o),
        .IF_ID_flush_o     (IF_ID_flush_o),
        .ID_EX_flush_o     (ID_EX_flush_o),
        .loaduse_cnt_o     (loaduse_cnt_o),
        .flush_cnt_o       (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] obs(input int sig);
        case (sig)
            S_F1:    return {14'd0, forward_rs1_sel_o};
            S_F2:    return {14'd0, forward_rs2_sel_o};
            S_EN:    return {11'd0, pc_en_o, IF_ID_en_o, ID_EX_en_o,
                             EX_MEM_en_o, MEM_WB_en_o};
            S_FL:    return {14'd0, IF_ID_flush_o, ID_EX_flush_o};
            S_LU:    return {12'd0, loaduse_cnt_o};
            S_FC:    return {12'd0, flush_cnt_o};
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic expect_v(input int sig, input logic [15:0] val,
                            input string tag);
        exp_t e;
        e.sig = sig;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [15:0] o;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sig);
            checks++;
            assert (o === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic [4:0] rd, input logic we,
                         input logic ld);
        ID_rs1_addr_i = r1;
        ID_rs1_used_i = u1;
        ID_rs2_addr_i = r2;
        ID_rs2_used_i = u2;
        ID_rd_addr_i  = rd;
        ID_rd_wren_i  = we;
        ID_mem_rden_i = ld;
    endtask

    task automatic drain();
        issue(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    initial begin
        rst_i            = 1'b1;
        EX_br_taken_i    = 1'b0;
        MEM_dmem_ready_i = 1'b1;
        issue(0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_v(S_F1, 16'h0,  "reset_fwd1");
        expect_v(S_F2, 16'h0,  "reset_fwd2");
        expect_v(S_EN, 16'h1f, "reset_en");
        expect_v(S_FL, 16'h0,  "reset_flush");
        expect_v(S_LU, 16'h0,  "reset_lucnt");
        expect_v(S_FC, 16'h0,  "reset_flcnt");
        check_now();
        rst_i = 1'b0;

        // producer in MEM
        issue(0, 0, 0, 0, 5, 1, 0);
        tick();
        issue(5, 1, 7, 1, 8, 1, 0);
        tick();
        expect_v(S_F1, 16'h1,  "fwd_mem_rs1");
        expect_v(S_F2, 16'h0,  "fwd_none_rs2");
        expect_v(S_EN, 16'h1f, "normal_en");
        check_now();

        // producer in WB
        issue(0, 0, 0, 0, 9, 1, 0);
        tick();
        issue(0, 0, 0, 0, 0, 0, 0);
        tick();
        issue(0, 0, 9, 1, 0, 0, 0);
        tick();
        expect_v(S_F2, 16'h2, "fwd_wb_rs2");
        expect_v(S_F1, 16'h0, "fwd_wb_rs1_unused");
        check_now();

        // producer in both MEM and WB
        issue(0, 0, 0, 0, 5, 1, 0);
        tick();
        issue(0, 0, 0, 0, 5, 1, 0);
        tick();
        issue(5, 1, 0, 0, 0, 0, 0);
        tick();
        expect_v(S_F1, 16'h1, "fwd_mem_wins");
        check_now();

        // x0 producer
        issue(0, 0, 0, 0, 0, 1, 0);
        tick();
        issue(0, 1, 0, 1, 0, 0, 0);
        tick();
        expect_v(S_F1, 16'h0, "fwd_x0_rs1");
        expect_v(S_F2, 16'h0, "fwd_x0_rs2");
        check_now();

        // load-use bubble
        drain();
        issue(2, 1, 0, 0, 6, 1, 1);
        tick();
        issue(1, 1, 6, 1, 10, 1, 0);
        expect_v(S_EN, 16'h07, "lu_en");
        expect_v(S_FL, 16'h1,  "lu_flush");
        expect_v(S_LU, 16'h0,  "lu_cnt_before");
        check_now();
        tick();
        expect_v(S_LU, 16'h1,  "lu_cnt_after");
        expect_v(S_EN, 16'h1f, "lu_resume_en");
        expect_v(S_FL, 16'h0,  "lu_resume_flush");
        check_now();
        tick();
        expect_v(S_F2, 16'h2, "lu_consumer_fwd_wb");
        expect_v(S_F1, 16'h0, "lu_consumer_rs1");
        check_now();

        // branch beats a simultaneous load-use
        drain();
        issue(0, 0, 0, 0, 6, 1, 1);
        tick();
        issue(6, 1, 0, 0, 0, 0, 0);
        EX_br_taken_i = 1'b1;
        expect_v(S_EN, 16'h1f, "br_lu_en");
        expect_v(S_FL, 16'h3,  "br_lu_flush");
        check_now();
        tick();
        EX_br_taken_i = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 0);
        expect_v(S_FC, 16'h1,  "br_flcnt");
        expect_v(S_LU, 16'h1,  "br_lucnt_held");
        expect_v(S_EN, 16'h1f, "br_after_en");
        check_now();

        // multi-cycle stall with pending branch
        drain();
        issue(0, 0, 0, 0, 5, 1, 0);
        tick();
        issue(5, 1, 0, 0, 11, 1, 0);
        tick();
        MEM_dmem_ready_i = 1'b0;
        EX_br_taken_i    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_v(S_EN, 16'h0, "stall_en");
            expect_v(S_FL, 16'h0, "stall_flush");
            expect_v(S_F1, 16'h1, "stall_fwd1");
            expect_v(S_FC, 16'h1, "stall_flcnt");
            check_now();
            tick();
        end
        MEM_dmem_ready_i = 1'b1;
        expect_v(S_FL, 16'h3,  "stall_end_flush");
        expect_v(S_EN, 16'h1f, "stall_end_en");
        check_now();
        tick();
        EX_br_taken_i = 1'b0;
        expect_v(S_FC, 16'h2, "stall_end_flcnt");
        expect_v(S_FL, 16'h0, "stall_end_once");
        check_now();

        // reset during a stall
        issue(0, 0, 0, 0, 5, 1, 0);
        tick();
        issue(5, 1, 0, 0, 0, 0, 0);
        tick();
        MEM_dmem_ready_i = 1'b0;
        EX_br_taken_i    = 1'b1;
        expect_v(S_F1, 16'h1, "pre_rst_fwd1");
        check_now();
        tick();
        rst_i = 1'b1;
        tick();
        expect_v(S_EN, 16'h1f, "rst_stall_en");
        expect_v(S_FL, 16'h0,  "rst_stall_flush");
        expect_v(S_F1, 16'h0,  "rst_stall_fwd1");
        expect_v(S_LU, 16'h0,  "rst_stall_lucnt");
        expect_v(S_FC, 16'h0,  "rst_stall_flcnt");
        check_now();
        rst_i            = 1'b0;
        MEM_dmem_ready_i = 1'b1;
        EX_br_taken_i    = 1'b0;

        // counter saturation
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            issue(0, 0, 0, 0, 6, 1, 1);
            tick();
            issue(6, 1, 0, 0, 0, 0, 0);
            tick();
            expect_v(S_LU, 16'((i + 1 > 15) ? 15 : i + 1), "sat_lucnt");
            check_now();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
